stack_controller: RTL
=====================

# stack_controller

Sequential stage directly downstream of `find_intersection` in the block-stacker datapath. It runs once per player drop:
- samples the drop and the intersection verdict;
- trims the dropped block to its overlap with the block beneath;
- commits the trimmed block as the new reference row that feeds back into `find_intersection`;
- advances the level and requests a new moving block.

It also owns the sticky game-over and win flags.

## Interface
Parameters:
- CELL_SHIFT, 4: log2 of the cell width in pixels (16-pixel cells).
- INIT_SIZE, 4: block size in cells at game start.
- MAX_LEVEL, 15: number of committed rows that wins the game.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  synchronous, active-high reset (the name is legacy; high = reset).
- stop_true  in  1  player drop strobe, the same signal that drives `find_intersection`.
- intersect_true  in  1  combinational verdict from `find_intersection`, valid in the same cycle as stop_true.
- curr_block_start  in  9  left pixel of the moving block.
- curr_block_end  in  9  right pixel of the moving block, inclusive.
- prev_block_start  out  9  left pixel of the top committed row.
- prev_block_end  out  9  right pixel of the top committed row, inclusive.
- prev_block_size  out  4  cell count of the top committed row.
- curr_block_size  out  4  cell count the mover must use for the next block.
- level  out  4  number of committed rows.
- spawn  out  1  one-cycle request to the mover to launch a new block of curr_block_size.
- busy  out  1  high while the FSM is in EVAL, COMMIT or START.
- game_over  out  1  sticky loss flag.
- win  out  1  sticky win flag.

## Operation
- FSM states: START, IDLE, EVAL, COMMIT, OVER, WIN. The reset state is START.
- START: spawn = 1 for exactly this cycle, then go to IDLE.
- IDLE: when stop_true = 1, latch curr_block_start, curr_block_end and intersect_true into staging registers and go to EVAL. When stop_true = 0, stay in IDLE.
- EVAL: compute the trimmed row.
  - first_row = (prev_block_start == 0 && prev_block_end == 0).
  - If first_row: new_start = latched start, new_end = latched end, new_size = curr_block_size. intersect_true is ignored.
  - Otherwise:
    - new_start = max(latched start, prev_block_start);
    - new_end = min(latched end, prev_block_end);
    - width = new_end − new_start + 1, computed at 10 bits;
    - new_size = width >> CELL_SHIFT, saturated to curr_block_size.
  - Go to OVER if (!first_row && latched intersect_true == 0), or new_end < new_start, or new_size == 0. Otherwise go to COMMIT.
- COMMIT:
  - prev_block_start ← new_start, prev_block_end ← new_end;
  - prev_block_size ← new_size, curr_block_size ← new_size;
  - level ← level + 1.
  - Next state is WIN if the old level == MAX_LEVEL − 1, else START.
- OVER: game_over = 1. Absorbing state; only reset leaves it. Committed registers stay frozen.
- WIN: win = 1. Absorbing state; only reset leaves it.
- stop_true is ignored in every state except IDLE. A held or repeated stop_true causes no second evaluation until IDLE is re-entered.
- busy = 1 in EVAL, COMMIT and START.

## Timing
- While resetn = 1, every output has its reset value:
  - prev_block_start = 0, prev_block_end = 0, prev_block_size = 0;
  - curr_block_size = INIT_SIZE, level = 0;
  - spawn = 0, busy = 0, game_over = 0, win = 0.
- Reset has priority over every state and transition, including mid-EVAL and mid-COMMIT. No partial commit survives reset.
- Reset release: the first cycle after resetn falls is START, so spawn = 1 in that cycle.
- Drop latency, with stop_true sampled in IDLE at edge T:
  - EVAL occupies cycle T..T+1.
  - COMMIT occupies cycle T+1..T+2.
  - The prev_*, size and level registers update at edge T+2 and are visible from T+2.
  - spawn is high in cycle T+2..T+3.
  - IDLE is re-entered at T+3.
- Miss path: game_over rises at edge T+2, and busy falls at the same edge.
- Win path: win rises at edge T+3, one edge after the final COMMIT. spawn is not asserted.
- All outputs are driven from flops; none combinationally depends on inputs.

## Test plan
- Reset then release:
  - all outputs hold their reset values while resetn = 1;
  - spawn = 1 for exactly one cycle after release;
  - busy = 1 during that cycle only.
- First drop, curr 64..127, intersect_true = 1 → prev 64..127, prev_block_size = 4, curr_block_size = 4, level = 1, spawn pulses 3 edges after the drop.
- Partial overlap, prev 64..127 and curr 96..159 → prev 96..127, size 2, level 2. A second stop_true while busy has no effect.
- Miss, prev 96..127, curr 160..191, intersect_true = 0 → game_over = 1, prev, size and level unchanged, subsequent stop_true ignored. Reset clears game_over.
- Sliver: prev 96..127 with size 2, curr 120..151, intersect_true = 1 → width 8 gives size 0 → game_over = 1, no commit.
- Win with MAX_LEVEL = 3: three aligned drops → level = 3, win = 1, no spawn after the third drop. A separate run asserts resetn during EVAL → reset values next cycle, then START and a spawn pulse.

Source files
------------

// File: rtl/stack_controller.sv
// stack_controller
//
// Per-drop sequencer for the block-stacker datapath. It captures a player
// drop, trims the dropped block to the part that overlaps the row beneath,
// commits the result as the new reference row, advances the level and asks
// the mover for a fresh block. It also holds the sticky game-over and win
// flags.
//
// Ports
//   clk               system clock, all state changes on the rising edge
//   resetn            synchronous reset, active HIGH (legacy name)
//   stop_true         player drop strobe
//   intersect_true    overlap verdict from find_intersection, same cycle as stop_true
//   curr_block_start  left pixel of the moving block
//   curr_block_end    right pixel of the moving block (inclusive)
//   prev_block_start  left pixel of the top committed row
//   prev_block_end    right pixel of the top committed row (inclusive)
//   prev_block_size   cell count of the top committed row
//   curr_block_size   cell count the mover must use for its next block
//   level             number of committed rows
//   spawn             one-cycle request to launch a new block
//   busy              high while a drop is being processed or a spawn is issued
//   game_over         sticky loss flag
//   win               sticky win flag
//
// Strobe semantics: stop_true is a level sampled only while the FSM sits in
// IDLE; one sampled high cycle starts exactly one evaluation, and the input is
// ignored everywhere else. spawn is a single-cycle pulse with no back-pressure:
// the mover must accept it in the cycle it is high.
//
// Every output is a flop. Flags that describe a state (busy, game_over, win)
// are written on the edge that acts on that state, so they lag state entry
// for the terminal states OVER and WIN by one cycle.

module stack_controller #(
    parameter int CELL_SHIFT = 4,
    parameter int INIT_SIZE  = 4,
    parameter int MAX_LEVEL  = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       stop_true,
    input  logic       intersect_true,
    input  logic [8:0] curr_block_start,
    input  logic [8:0] curr_block_end,
    output logic [8:0] prev_block_start,
    output logic [8:0] prev_block_end,
    output logic [3:0] prev_block_size,
    output logic [3:0] curr_block_size,
    output logic [3:0] level,
    output logic       spawn,
    output logic       busy,
    output logic       game_over,
    output logic       win
);

    localparam logic [2:0] START  = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] EVAL   = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] OVER   = 3'd4;
    localparam logic [2:0] WIN    = 3'd5;

    localparam logic [3:0] INIT_SIZE_V = 4'(INIT_SIZE);
    localparam logic [3:0] LAST_LEVEL  = 4'(MAX_LEVEL - 1);

    logic [2:0] state;

    // Drop captured in IDLE, stable for the whole evaluation.
    logic [8:0] stg_start;
    logic [8:0] stg_end;
    logic       stg_hit;

    // Trimmed row produced by EVAL and written out in COMMIT.
    logic [8:0] new_start;
    logic [8:0] new_end;
    logic [3:0] new_size;

    // Evaluation datapath, purely a function of the staging and committed rows.
    logic       first_row;
    logic [8:0] max_start;
    logic [8:0] min_end;
    logic [9:0] width;
    logic [9:0] width_cells;
    logic [3:0] trim_size;
    logic [8:0] eval_start;
    logic [8:0] eval_end;
    logic [3:0] eval_size;
    logic       eval_fail;

    always_comb begin
        first_row   = (prev_block_start == 9'd0) && (prev_block_end == 9'd0);
        max_start   = (stg_start > prev_block_start) ? stg_start : prev_block_start;
        min_end     = (stg_end < prev_block_end) ? stg_end : prev_block_end;
        // Extended to 10 bits so a full 0..511 span does not wrap.
        width       = {1'b0, min_end} - {1'b0, max_start} + 10'd1;
        width_cells = width >> CELL_SHIFT;
        // A row can never grow, so the cell count is capped at the current size.
        if (width_cells > {6'd0, curr_block_size}) begin
            trim_size = curr_block_size;
        end else begin
            trim_size = width_cells[3:0];
        end

        if (first_row) begin
            // Nothing beneath yet: the whole block lands and the verdict is moot.
            eval_start = stg_start;
            eval_end   = stg_end;
            eval_size  = curr_block_size;
        end else begin
            eval_start = max_start;
            eval_end   = min_end;
            eval_size  = trim_size;
        end

        eval_fail = (!first_row && !stg_hit) ||
                    (eval_end < eval_start) ||
                    (eval_size == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state            <= START;
            stg_start        <= 9'd0;
            stg_end          <= 9'd0;
            stg_hit          <= 1'b0;
            new_start        <= 9'd0;
            new_end          <= 9'd0;
            new_size         <= 4'd0;
            prev_block_start <= 9'd0;
            prev_block_end   <= 9'd0;
            prev_block_size  <= 4'd0;
            curr_block_size  <= INIT_SIZE_V;
            level            <= 4'd0;
            spawn            <= 1'b0;
            busy             <= 1'b0;
            game_over        <= 1'b0;
            win              <= 1'b0;
        end else begin
            case (state)
                START: begin
                    // START is entered either from reset (spawn still low, so
                    // raise it now) or from COMMIT (spawn already raised on
                    // entry). Either way spawn is high for exactly one cycle.
                    if (spawn) begin
                        spawn <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        spawn <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                IDLE: begin
                    if (stop_true) begin
                        stg_start <= curr_block_start;
                        stg_end   <= curr_block_end;
                        stg_hit   <= intersect_true;
                        busy      <= 1'b1;
                        state     <= EVAL;
                    end
                end

                EVAL: begin
                    new_start <= eval_start;
                    new_end   <= eval_end;
                    new_size  <= eval_size;
                    state     <= eval_fail ? OVER : COMMIT;
                end

                COMMIT: begin
                    prev_block_start <= new_start;
                    prev_block_end   <= new_end;
                    prev_block_size  <= new_size;
                    curr_block_size  <= new_size;
                    level            <= level + 4'd1;
                    if (level == LAST_LEVEL) begin
                        // Final row: no new block is requested.
                        state <= WIN;
                    end else begin
                        spawn <= 1'b1;
                        state <= START;
                    end
                end

                OVER: begin
                    game_over <= 1'b1;
                    busy      <= 1'b0;
                end

                WIN: begin
                    win  <= 1'b1;
                    busy <= 1'b0;
                end

                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule
